// File: rtl/g9_loader_pkg.sv
// rtl/g9_loader_pkg.sv - shared types and constants for the instruction memory loader
package g9_loader_pkg;

  localparam int DEF_SIZE     = 32;
  localparam int DEF_MEM_SIZE = 512;
  localparam int DEF_ADDR_W   = 9;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } load_state_t;

  // DONE and ERROR are only left through reset.
  function automatic logic is_terminal(input load_state_t s);
    return (s == ST_DONE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// rtl/loader_word_assembler.sv - big-endian byte-to-word packer with running XOR checksum
module loader_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic        o_word_ready,
  output logic [31:0] o_word,
  output logic [7:0]  o_xor_acc
);

  logic [23:0] r_shift;
  logic [1:0]  r_idx;
  logic [7:0]  r_acc;

  // The completing byte is merged combinationally so the top can register
  // the memory write on the very edge that consumes it.
  assign o_word_ready = i_byte_en && (r_idx == 2'd3);
  assign o_word       = {r_shift, i_byte};
  assign o_xor_acc    = r_acc;

  always_ff @(posedge clk) begin
    if (!reset || i_clear) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
    end else if (i_byte_en) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_idx   <= r_idx + 2'd1;
      r_acc   <= r_acc ^ i_byte;
    end
  end

endmodule

// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - framed boot loader writing instruction memory port A
module imem_program_loader
  import g9_loader_pkg::*;
#(
  parameter int SIZE     = DEF_SIZE,
  parameter int MEM_SIZE = DEF_MEM_SIZE,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_wea,
  output logic [SIZE-1:0]   imem_addra,
  output logic [SIZE-1:0]   imem_dina,
  output logic              cpu_run,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  load_state_t r_state, w_next_state;

  logic [7:0]      r_count_hi;
  logic [15:0]     r_count;
  logic [ADDR_W:0] r_words;
  logic            r_rx_ready;
  logic            r_wea;
  logic [SIZE-1:0] r_addra;
  logic [SIZE-1:0] r_dina;
  logic            r_done;
  logic            r_error;

  logic        w_fire;
  logic        w_data_en;
  logic        w_word_done;
  logic [31:0] w_word_next;
  logic [7:0]  w_xor_acc;
  logic [15:0] w_hdr_count;
  logic [15:0] w_words_inc;

  assign w_fire      = r_rx_ready && rx_valid;
  assign w_data_en   = w_fire && (r_state == ST_DATA);
  assign w_hdr_count = {r_count_hi, rx_data};
  assign w_words_inc = 16'(r_words) + 16'd1;

  loader_word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (r_state == ST_IDLE),
    .i_byte_en    (w_data_en),
    .i_byte       (rx_data),
    .o_word_ready (w_word_done),
    .o_word       (w_word_next),
    .o_xor_acc    (w_xor_acc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_fire && (rx_data == SYNC_BYTE)) w_next_state = ST_HDR_HI;
      end
      ST_HDR_HI: begin
        if (w_fire) w_next_state = ST_HDR_LO;
      end
      ST_HDR_LO: begin
        if (w_fire) begin
          if (w_hdr_count == 16'd0)                w_next_state = ST_CSUM;
          else if (w_hdr_count > 16'(MEM_SIZE))    w_next_state = ST_ERROR;
          else                                     w_next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_word_done && (w_words_inc == r_count)) w_next_state = ST_CSUM;
      end
      ST_CSUM: begin
        if (w_fire) w_next_state = (rx_data == w_xor_acc) ? ST_DONE : ST_ERROR;
      end
      ST_DONE:  w_next_state = ST_DONE;
      ST_ERROR: w_next_state = ST_ERROR;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Every output is registered from the next-state decision of the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count_hi <= '0;
      r_count    <= '0;
      r_words    <= '0;
      r_rx_ready <= 1'b0;
      r_wea      <= 1'b0;
      r_addra    <= '0;
      r_dina     <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      if ((r_state == ST_HDR_HI) && w_fire) r_count_hi <= rx_data;
      if ((r_state == ST_HDR_LO) && w_fire) r_count    <= w_hdr_count;

      r_rx_ready <= !is_terminal(w_next_state);
      r_wea      <= w_word_done;
      if (w_word_done) begin
        r_addra <= {{(SIZE-ADDR_W){1'b0}}, r_words[ADDR_W-1:0]};
        r_dina  <= w_word_next;
        r_words <= r_words + 1'b1;
      end

      r_done  <= (w_next_state == ST_DONE);
      r_error <= (w_next_state == ST_ERROR);
    end
  end

  assign rx_ready     = r_rx_ready;
  assign imem_wea     = r_wea;
  assign imem_addra   = r_addra;
  assign imem_dina    = r_dina;
  assign cpu_run      = r_done;
  assign load_done    = r_done;
  assign load_error   = r_error;
  assign words_loaded = r_words;

endmodule
